// File: rtl/mix_columns_seq.sv
// AES MixColumns/InvMixColumns over a 128-bit state, COLS_PER_CYCLE columns per clock.
// Result valid 4/COLS_PER_CYCLE cycles after accept; held in DONE until out_ready, no accept meanwhile.
module mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
            $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [2:0]     r_col_cnt;
    logic [127:0]   r_work;
    logic           r_inv;
    logic [127:0]   r_out;
    logic           r_out_vld;
    logic [127:0]   w_mixed;
    logic           w_last;
    logic           w_in_ready;
    logic           w_busy;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Inverse coefficients are sums of s, 2s, 4s, 8s taken from one xt chain per byte.
    function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
        logic [7:0] s[4];
        logic [7:0] x2[4];
        logic [7:0] x4[4];
        logic [7:0] x8[4];
        logic [7:0] m9[4];
        logic [7:0] mb[4];
        logic [7:0] md[4];
        logic [7:0] me[4];
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            s[i]  = c[31-8*i -: 8];
            x2[i] = xt(s[i]);
            x4[i] = xt(x2[i]);
            x8[i] = xt(x4[i]);
            m9[i] = x8[i] ^ s[i];
            mb[i] = x8[i] ^ x2[i] ^ s[i];
            md[i] = x8[i] ^ x4[i] ^ s[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        if (inv) begin
            r = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                 m9[0] ^ me[1] ^ mb[2] ^ md[3],
                 md[0] ^ m9[1] ^ me[2] ^ mb[3],
                 mb[0] ^ md[1] ^ m9[2] ^ me[3]};
        end else begin
            r = {x2[0] ^ x2[1] ^ s[1] ^ s[2] ^ s[3],
                 s[0] ^ x2[1] ^ x2[2] ^ s[2] ^ s[3],
                 s[0] ^ s[1] ^ x2[2] ^ x2[3] ^ s[3],
                 x2[0] ^ s[0] ^ s[1] ^ s[2] ^ x2[3]};
        end
        return r;
    endfunction

    always_comb begin
        w_mixed = r_work;
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            automatic logic [6:0] lo = 7'(96 - 32 * (int'(r_col_cnt) + g));
            w_mixed[lo +: 32] = mix_col(r_work[lo +: 32], r_inv);
        end
    end

    assign w_last = (r_col_cnt == 3'(4 - COLS_PER_CYCLE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b0;
                if (in_valid) w_state_nxt = RUN;
            end
            RUN:     if (w_last) w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_work    <= '0;
            r_inv     <= 1'b0;
            r_col_cnt <= '0;
            r_out     <= '0;
            r_out_vld <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_work    <= in_state;
                    r_inv     <= in_inv;
                    r_col_cnt <= '0;
                end
                RUN: begin
                    r_work    <= w_mixed;
                    r_col_cnt <= r_col_cnt + 3'(COLS_PER_CYCLE);
                    if (w_last) begin
                        r_out     <= w_mixed;
                        r_out_vld <= 1'b1;
                    end
                end
                DONE:    if (out_ready) r_out_vld <= 1'b0;
                default: r_out_vld <= 1'b0;
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign busy      = w_busy;
    assign out_valid = r_out_vld;
    assign out_state = r_out;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: one instance per legal COLS_PER_CYCLE, checked against a GF(2^8) matrix model.
module tb_mix_columns_seq;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [2:0]        in_valid = '0;
    logic [2:0]        in_inv = '0;
    logic [2:0]        out_ready = '0;
    logic [2:0][127:0] in_state = '0;
    logic [2:0]        in_ready;
    logic [2:0]        out_valid;
    logic [2:0]        busy;
    logic [2:0][127:0] out_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mix_columns_seq #(.COLS_PER_CYCLE(1)) u_c1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_state(in_state[0]), .in_inv(in_inv[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_state(out_state[0]), .busy(busy[0]));
    mix_columns_seq #(.COLS_PER_CYCLE(2)) u_c2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_state(in_state[1]), .in_inv(in_inv[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_state(out_state[1]), .busy(busy[1]));
    mix_columns_seq #(.COLS_PER_CYCLE(4)) u_c4 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_state(in_state[2]), .in_inv(in_inv[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .out_state(out_state[2]), .busy(busy[2]));

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
        end
        return p;
    endfunction

    // Circulant matrix product: row r uses coefficient row shifted right by r.
    function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
        logic [7:0] coef[4];
        logic [127:0] r = '0;
        logic [7:0] acc;
        if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(coef[(j - row + 4) % 4], s[127-32*c-8*j -: 8]);
                r[127-32*c-8*row -: 8] = acc;
            end
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Accept one state, flip in_inv while running, wait (bounded) for the result, then drain it.
    task automatic xact(input int k, input logic [127:0] s, input logic inv,
                        output logic [127:0] res, output int lat);
        @(negedge clk);
        check("in_ready_before_accept", 128'(in_ready[k]), 128'(1));
        in_valid[k] = 1'b1;
        in_state[k] = s;
        in_inv[k]   = inv;
        @(posedge clk);
        #1;
        in_valid[k] = 1'b0;
        in_inv[k]   = ~inv;
        in_state[k] = '0;
        lat = 0;
        while (!out_valid[k] && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = out_state[k];
        out_ready[k] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[k] = 1'b0;
    endtask

    initial begin
        logic [127:0] res, res2, s, exp;
        int lat;

        #2;
        for (int k = 0; k < 3; k++) begin
            check("rst_in_ready", 128'(in_ready[k]), 128'(1));
            check("rst_out_valid", 128'(out_valid[k]), 128'(0));
            check("rst_out_state", out_state[k], 128'(0));
            check("rst_busy", 128'(busy[k]), 128'(0));
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        xact(0, 128'hdb135345_f20a225c_01010101_2d26314c, 1'b0, res, lat);
        check("fwd_c1_state", res, 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8);
        check("fwd_c1_latency", 128'(lat), 128'(4));

        xact(2, 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8, 1'b1, res, lat);
        check("inv_c4_state", res, 128'hdb135345_f20a225c_01010101_2d26314c);
        check("inv_c4_latency", 128'(lat), 128'(1));

        // Backpressure on the two-column engine.
        s = {$urandom, $urandom, $urandom, $urandom};
        exp = ref_mix(s, 1'b0);
        @(negedge clk);
        in_valid[1] = 1'b1;
        in_state[1] = s;
        in_inv[1]   = 1'b0;
        @(posedge clk);
        #1;
        in_valid[1] = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("bp_valid_rise", 128'(out_valid[1]), 128'(1));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", 128'(out_valid[1]), 128'(1));
            check("bp_out_state", out_state[1], exp);
            check("bp_in_ready", 128'(in_ready[1]), 128'(0));
            check("bp_busy", 128'(busy[1]), 128'(1));
        end
        out_ready[1] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[1] = 1'b0;
        check("bp_release_valid", 128'(out_valid[1]), 128'(0));
        check("bp_release_in_ready", 128'(in_ready[1]), 128'(1));
        check("bp_release_busy", 128'(busy[1]), 128'(0));
        check("bp_release_state_kept", out_state[1], exp);

        // Reset two cycles into RUN on the single-column engine.
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_state[0] = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 128'(out_valid[0]), 128'(0));
        check("midrst_out_state", out_state[0], 128'(0));
        check("midrst_in_ready", 128'(in_ready[0]), 128'(1));
        check("midrst_busy", 128'(busy[0]), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        s = {64'hc6c6c6c6_d4d4d4d5, $urandom, $urandom};
        xact(0, s, 1'b0, res, lat);
        check("after_rst_cols01", 128'(res[127:64]), 128'(64'hc6c6c6c6_d5d5d7d6));
        check("after_rst_full", res, ref_mix(s, 1'b0));
        check("after_rst_latency", 128'(lat), 128'(4));

        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 1000; n++) begin
                s = {$urandom, $urandom, $urandom, $urandom};
                xact(k, s, 1'b0, res, lat);
                check("rand_fwd", res, ref_mix(s, 1'b0));
                check("rand_fwd_latency", 128'(lat), 128'(4 / (1 << k)));
                xact(k, res, 1'b1, res2, lat);
                check("rand_inv", res2, ref_mix(res, 1'b1));
                check("rand_roundtrip", res2, s);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
